// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: sequences single-byte RTC register reads/writes onto the multiplexed address/data bus
module rtc_bus_sequencer #(
    parameter int T_PHASE = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic       ad_oe,
    output logic [7:0] ad_out,
    input  logic [7:0] ad_in
);
    localparam int CW = $clog2(T_PHASE + 1);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic          pend_q, pend_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cs_n_q, cs_n_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          ad_sel_q, ad_sel_d;
    logic          ad_oe_q, ad_oe_d;
    logic [7:0]    ad_out_q, ad_out_d;
    logic          last, accept, a_ph, d_ph;

    assign last   = cnt_q == CW'(T_PHASE - 1);
    assign accept = (state_q == IDLE || (state_q == DONE && !pend_q)) && (wr_req || rd_req);

    // Sequencing: acceptance/arbitration, phase timing and read capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        pend_d    = pend_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        if (accept) begin
            // A simultaneous write and read share addr: the write goes first, the read waits in the pending slot
            state_d = A_SETUP;
            cnt_d   = '0;
            is_wr_d = wr_req;
            pend_d  = wr_req && rd_req;
            addr_d  = addr;
            data_d  = wr_data;
        end else if (state_q == DONE) begin
            state_d = pend_q ? A_SETUP : IDLE;
            cnt_d   = '0;
            is_wr_d = pend_q ? 1'b0 : is_wr_q;
            pend_d  = 1'b0;
        end else if (state_q != IDLE) begin
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            state_d = last ? state_t'(state_q + 3'd1) : state_q;
            rd_data_d = (last && state_q == D_STROBE && !is_wr_q) ? ad_in : rd_data_q;
        end
    end

    // Pin values decoded from the upcoming state so every output leaves a flop
    always_comb begin
        a_ph     = state_d inside {A_SETUP, A_STROBE, A_HOLD};
        d_ph     = state_d inside {D_SETUP, D_STROBE, D_HOLD};
        busy_d   = state_d != IDLE;
        done_d   = state_d == DONE;
        cs_n_d   = !(state_d == A_STROBE || state_d == D_STROBE);
        wr_n_d   = !(state_d == A_STROBE || (state_d == D_STROBE && is_wr_d));
        rd_n_d   = !(state_d == D_STROBE && !is_wr_d);
        ad_sel_d = !a_ph;
        ad_oe_d  = a_ph || (d_ph && is_wr_d);
        ad_out_d = ad_oe_d ? (a_ph ? addr_d : data_d) : 8'h00;
    end

    // State and output registers; reset aborts any transaction without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            pend_q    <= 1'b0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            rd_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_sel_q  <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_sel_q  <= ad_sel_d;
            ad_oe_q   <= ad_oe_d;
            ad_out_q  <= ad_out_d;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cs_n    = cs_n_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign ad_sel  = ad_sel_q;
    assign ad_oe   = ad_oe_q;
    assign ad_out  = ad_out_q;
endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Bus sequencer between the PicoBlaze-side RTC register block and the external RTC chip's multiplexed address/data bus. It accepts single-byte read or write requests, then drives the chip-select, strobe and A/D-select pins through a fixed address-phase/data-phase sequence. For reads, it captures the returned byte. It also arbitrates simultaneous read and write requests, holding a one-deep pending read.

## Interface

- T_PHASE, 10, clock cycles per bus phase (≥1); 100 ns at 100 MHz
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- wr_req  in  1  one-cycle write request pulse
- rd_req  in  1  one-cycle read request pulse
- addr  in  8  RTC register address, sampled with the accepted request
- wr_data  in  8  write byte, sampled with an accepted write
- rd_data  out  8  last byte read; holds its value until the next read completes
- busy  out  1  high from acceptance until the cycle after done
- done  out  1  one-cycle pulse when a transaction ends
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  RTC read strobe, active low
- wr_n  out  1  RTC write strobe, active low
- ad_sel  out  1  0 = address phase, 1 = data phase
- ad_oe  out  1  tristate enable for the AD bus pad
- ad_out  out  8  value driven onto the AD bus
- ad_in  in  8  AD bus pad input

## Operation

- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE.
- Each state from A_SETUP through D_HOLD lasts exactly T_PHASE cycles, timed by a phase counter of width clog2(T_PHASE+1). DONE lasts 1 cycle.
- IDLE: cs_n=rd_n=wr_n=1, ad_sel=1, ad_oe=0, busy=0.
- A_SETUP: ad_sel=0, ad_oe=1, ad_out=latched address; strobes high.
- A_STROBE: cs_n=0, wr_n=0 (the address is always latched with a write strobe); address still driven.
- A_HOLD: cs_n=wr_n=1; address still driven, ad_sel=0.
- D_SETUP: ad_sel=1.
  - Write: ad_oe=1, ad_out=latched data.
  - Read: ad_oe=0.
- D_STROBE: cs_n=0.
  - Write: wr_n=0, data still driven.
  - Read: rd_n=0; ad_in is registered into rd_data on the last cycle of the phase.
- D_HOLD: strobes high. A write keeps driving data; a read keeps ad_oe=0.
- DONE: done=1, ad_oe=0, then the next state is chosen:
  - a pending read exists → A_SETUP;
  - otherwise → IDLE.
- Acceptance happens only in IDLE, or in DONE when nothing is pending. addr and wr_data are latched on the acceptance edge.
- Arbitration: if wr_req and rd_req are both high in the same accepting cycle, the write is served first. The read and its addr are latched into the pending slot.
  - With a simultaneous request, both operations share the same addr.
- Requests arriving while busy=1 and not in an accepting cycle are dropped. The requester waits for done.
- ad_out is 0x00 whenever ad_oe=0.
- No strobe is ever asserted while ad_sel is changing: ad_sel only changes in the setup phases.
- Reset (any time, including mid-transaction): all outputs return to IDLE values immediately, rd_data=0x00, the pending slot is cleared and the phase counter is cleared. No done pulse is produced for an aborted transaction.

## Timing

- Request accepted at edge N → A_SETUP starts at N+1. The done pulse is in cycle N+1+6·T_PHASE. busy falls the cycle after done, unless a new request or pending read is accepted.
- cs_n low time per strobe: exactly T_PHASE cycles. Minimum cs_n high between address and data strobes: 2·T_PHASE cycles.
- rd_data updates at the end of D_STROBE and is stable before done rises.
- Back-to-back: a request pulsed in the DONE cycle is accepted there. A_SETUP of the new transaction follows with no IDLE cycle.
- Reset output values: cs_n=rd_n=wr_n=1, ad_sel=1, ad_oe=0, ad_out=0x00, rd_data=0x00, busy=0, done=0.

## Test plan

- Write, T_PHASE=2: addr=0x21, wr_data=0x45 → ad_out=0x21 with ad_sel=0 and wr_n=0 for 2 cycles; then ad_out=0x45 with ad_sel=1 and wr_n=0 for 2 cycles; done at cycle 13 after acceptance; rd_n stays high throughout.
- Read with ad_in=0x37, addr=0x22 → address phase as above, rd_n=0 for 2 cycles in the data phase, ad_oe=0 throughout the data phase; rd_data=0x37 at done; wr_n stays high throughout the data phase.
- wr_req and rd_req together, addr=0x23 → a write transaction, done, then the read starts immediately with no IDLE cycle; two done pulses 13 cycles apart.
- rd_req pulsed during D_STROBE of a write → dropped; exactly one done; busy falls after it.
- Reset asserted during a read's D_STROBE → cs_n=rd_n=1, ad_oe=0 and busy=0 asynchronously; rd_data=0x00; no done pulse. After release, a new write completes normally.
- T_PHASE=1 with 10 random read/write transactions → the strobe/ad_sel invariants hold, the ad_oe=0 ⇒ ad_out=0x00 invariant holds, and every read returns the bench model's ad_in value.
